// File: rtl/ifetch_stream.sv
// ifetch_stream: instruction-fetch unit with a DEPTH-entry PC-tagged fetch buffer.
// Drives a 1-cycle-latency synchronous instruction memory. Each returned word is
// tagged with its PC and handed to decode over valid/ready. A branch redirect
// flushes the buffer and drops the in-flight response. While the UART uploader
// owns the memory port, fetch is idle and the upload write port is passed through.
// Note: rst_n is active-high (1 = reset) in spite of its name.
module ifetch_stream #(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 4,
    parameter int RESET_PC = 0,
    parameter int PC_STEP  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_addr_i,
    output logic [DATA_W-1:0] instr_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              imem_en_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [DATA_W-1:0] imem_wdata_o,
    input  logic [DATA_W-1:0] imem_rdata_i,
    input  logic              upg_rst_i,
    input  logic              upg_wen_i,
    input  logic [ADDR_W-1:0] upg_addr_i,
    input  logic [DATA_W-1:0] upg_data_i,
    input  logic              upg_done_i,
    output logic              prog_mode_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;

    localparam logic [ADDR_W-1:0] PC_RST    = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] PC_INC    = ADDR_W'(PC_STEP);
    localparam logic [OCC_W-1:0]  OCC_DEPTH = OCC_W'(DEPTH);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    // Fetch-side state
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_tag;
    logic              r_inflight;

    // Buffer state
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [DATA_W-1:0] r_buf_instr [DEPTH];
    logic [ADDR_W-1:0] r_buf_pc    [DEPTH];

    logic              w_run;
    logic              w_flush;
    logic              w_valid;
    logic              w_pop;
    logic              w_push;
    logic              w_issue;
    logic [OCC_W-1:0]  w_occ;

    // Run when the uploader is idle or has finished; otherwise it owns the port.
    assign w_run       = upg_rst_i | upg_done_i;
    assign prog_mode_o = ~w_run;

    // A redirect or upload mode throws away everything buffered or in flight.
    assign w_flush = ~w_run | redirect_i;

    // The head is hidden during a redirect cycle so a stale word is never consumed.
    assign w_valid = ~rst_n & (r_count != '0) & ~redirect_i & w_run;
    assign w_pop   = w_valid & ready_i;
    assign w_push  = r_inflight & ~w_flush;

    // Occupancy after this cycle's pop, counting the word still in the memory
    // pipeline, so an issued request always has a free slot when it returns.
    assign w_occ = {1'b0, r_count}
                 + {{CNT_W{1'b0}}, r_inflight}
                 - {{CNT_W{1'b0}}, w_pop};

    assign w_issue = ~rst_n & w_run & ~redirect_i & (w_occ < OCC_DEPTH);

    // PC, request tag and in-flight flag
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_pc       <= PC_RST;
            r_tag      <= PC_RST;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_tag <= r_pc;
            end
            if (!w_run) begin
                r_pc <= PC_RST;
            end else if (redirect_i) begin
                r_pc <= redirect_addr_i;
            end else if (w_issue) begin
                r_pc <= r_pc + PC_INC;
            end
        end
    end

    // Buffer occupancy and read/write pointers
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else if (w_flush) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

    // Buffer storage; contents are qualified by r_count so no reset is needed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_instr[r_wr_ptr] <= imem_rdata_i;
            r_buf_pc[r_wr_ptr]    <= r_tag;
        end
    end

    // Memory port: fetch reads in run mode, uploader writes pass straight through otherwise
    always_comb begin
        imem_en_o    = 1'b0;
        imem_we_o    = 1'b0;
        imem_addr_o  = r_pc;
        imem_wdata_o = '0;
        if (w_run) begin
            imem_en_o = w_issue;
        end else begin
            imem_en_o    = ~rst_n & upg_wen_i;
            imem_we_o    = ~rst_n & upg_wen_i;
            imem_addr_o  = upg_addr_i;
            imem_wdata_o = upg_data_i;
        end
    end

    // Decode-side view of the buffer head
    always_comb begin
        valid_o = w_valid;
        instr_o = r_buf_instr[r_rd_ptr];
        pc_o    = r_buf_pc[r_rd_ptr];
    end

endmodule

// File: tb/tb_ifetch_stream.sv
// Directed bench for ifetch_stream: streaming, backpressure, redirect, address
// wrap, program upload and asynchronous reset, against a bench-owned memory.
module tb_ifetch_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_i;
    logic [13:0] redirect_addr_i;
    logic [31:0] instr_o;
    logic [13:0] pc_o;
    logic        valid_o;
    logic        ready_i;
    logic        imem_en_o;
    logic        imem_we_o;
    logic [13:0] imem_addr_o;
    logic [31:0] imem_wdata_o;
    logic [31:0] imem_rdata_i;
    logic        upg_rst_i;
    logic        upg_wen_i;
    logic [13:0] upg_addr_i;
    logic [31:0] upg_data_i;
    logic        upg_done_i;
    logic        prog_mode_o;

    int checks = 0;
    int errors = 0;
    bit uploaded = 1'b0;

    logic [31:0] mem [16384];

    ifetch_stream dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_i      (redirect_i),
        .redirect_addr_i (redirect_addr_i),
        .instr_o         (instr_o),
        .pc_o            (pc_o),
        .valid_o         (valid_o),
        .ready_i         (ready_i),
        .imem_en_o       (imem_en_o),
        .imem_we_o       (imem_we_o),
        .imem_addr_o     (imem_addr_o),
        .imem_wdata_o    (imem_wdata_o),
        .imem_rdata_i    (imem_rdata_i),
        .upg_rst_i       (upg_rst_i),
        .upg_wen_i       (upg_wen_i),
        .upg_addr_i      (upg_addr_i),
        .upg_data_i      (upg_data_i),
        .upg_done_i      (upg_done_i),
        .prog_mode_o     (prog_mode_o)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory, one cycle latency
    always @(posedge clk) begin
        if (imem_en_o && imem_we_o) mem[imem_addr_o] <= imem_wdata_o;
        if (imem_en_o && !imem_we_o) imem_rdata_i <= mem[imem_addr_o];
    end

    function automatic logic [31:0] exp_word(input logic [13:0] a);
        if (uploaded && a == 14'd5) return 32'hDEADBEEF;
        return 32'h1000 + 32'(a);
    endfunction

    task automatic do_reset();
        rst_n = 1'b1; redirect_i = 1'b0; redirect_addr_i = '0; ready_i = 1'b1;
        upg_rst_i = 1'b1; upg_done_i = 1'b0; upg_wen_i = 1'b0; upg_addr_i = '0; upg_data_i = '0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; redirect_i = 1'b0; redirect_addr_i = '0; ready_i = 1'b1;
        upg_rst_i = 1'b1; upg_done_i = 1'b0; upg_wen_i = 1'b0; upg_addr_i = '0; upg_data_i = '0;
        @(negedge clk); #1;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", valid_o); end
        checks++; if (imem_en_o !== 1'b0) begin errors++; $display("FAIL rst_en got %b exp 0", imem_en_o); end
        checks++; if (prog_mode_o !== 1'b0) begin errors++; $display("FAIL rst_prog got %b exp 0", prog_mode_o); end
        // uploader writing while reset is held must not reach memory
        upg_rst_i = 1'b0; upg_wen_i = 1'b1; upg_addr_i = 14'd9; #1;
        checks++; if (imem_en_o !== 1'b0) begin errors++; $display("FAIL rst_upg_en got %b exp 0", imem_en_o); end
        checks++; if (imem_we_o !== 1'b0) begin errors++; $display("FAIL rst_upg_we got %b exp 0", imem_we_o); end
        upg_rst_i = 1'b1; upg_wen_i = 1'b0; upg_addr_i = '0;
        @(negedge clk);
        rst_n = 1'b0; #1;
        checks++; if (imem_en_o !== 1'b1) begin errors++; $display("FAIL rst_rel_en got %b exp 1", imem_en_o); end
        checks++; if (imem_addr_o !== 14'd0) begin errors++; $display("FAIL rst_rel_addr got %h exp 0000", imem_addr_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_rel_valid got %b exp 0", valid_o); end
    endtask

    task automatic test_stream();
        do_reset();
        for (int c = 0; c < 12; c++) begin
            #1;
            checks++; if (imem_en_o !== 1'b1 || imem_addr_o !== 14'(c)) begin
                errors++; $display("FAIL stream_issue c=%0d got en=%b addr=%h exp en=1 addr=%h", c, imem_en_o, imem_addr_o, 14'(c)); end
            if (c < 2) begin
                checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL stream_lat c=%0d got %b exp 0", c, valid_o); end
            end else begin
                checks++; if (valid_o !== 1'b1 || pc_o !== 14'(c-2) || instr_o !== exp_word(14'(c-2))) begin
                    errors++; $display("FAIL stream_out c=%0d got v=%b pc=%h i=%h exp v=1 pc=%h i=%h",
                                       c, valid_o, pc_o, instr_o, 14'(c-2), exp_word(14'(c-2))); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic [13:0] exp_pc = '0;
        do_reset();
        for (int c = 0; c < 25; c++) begin
            ready_i = !(c >= 5 && c < 15);
            #1;
            if (c == 6) begin
                checks++; if (imem_en_o !== 1'b1) begin errors++; $display("FAIL bp_en6 got %b exp 1", imem_en_o); end
            end
            if (c >= 7 && c < 15) begin
                checks++; if (imem_en_o !== 1'b0) begin errors++; $display("FAIL bp_full_en c=%0d got %b exp 0", c, imem_en_o); end
                checks++; if (valid_o !== 1'b1 || pc_o !== 14'd3) begin
                    errors++; $display("FAIL bp_head c=%0d got v=%b pc=%h exp v=1 pc=0003", c, valid_o, pc_o); end
            end
            if (c == 15) begin
                checks++; if (imem_en_o !== 1'b1 || imem_addr_o !== 14'd7) begin
                    errors++; $display("FAIL bp_resume got en=%b addr=%h exp en=1 addr=0007", imem_en_o, imem_addr_o); end
            end
            if (valid_o && ready_i) begin
                checks++; if (pc_o !== exp_pc || instr_o !== exp_word(exp_pc)) begin
                    errors++; $display("FAIL bp_order c=%0d got pc=%h i=%h exp pc=%h i=%h", c, pc_o, instr_o, exp_pc, exp_word(exp_pc)); end
                exp_pc++;
            end
            @(negedge clk);
        end
        checks++; if (exp_pc !== 14'd13) begin errors++; $display("FAIL bp_popcount got %0d exp 13", exp_pc); end
    endtask

    task automatic test_redirect();
        do_reset();
        redirect_addr_i = 14'h0200;
        for (int c = 0; c < 12; c++) begin
            ready_i = !(c >= 5 && c < 7);
            redirect_i = (c == 7);
            #1;
            case (c)
                7: begin
                    checks++; if (valid_o !== 1'b0 || imem_en_o !== 1'b0) begin
                        errors++; $display("FAIL redir_cycle got v=%b en=%b exp v=0 en=0", valid_o, imem_en_o); end
                end
                8: begin
                    checks++; if (imem_en_o !== 1'b1 || imem_addr_o !== 14'h0200) begin
                        errors++; $display("FAIL redir_target got en=%b addr=%h exp en=1 addr=0200", imem_en_o, imem_addr_o); end
                    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL redir_stale8 got %b exp 0", valid_o); end
                end
                9: begin
                    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL redir_stale9 got %b exp 0", valid_o); end
                end
                10: begin
                    checks++; if (valid_o !== 1'b1 || pc_o !== 14'h0200 || instr_o !== 32'h1200) begin
                        errors++; $display("FAIL redir_first got v=%b pc=%h i=%h exp v=1 pc=0200 i=00001200", valid_o, pc_o, instr_o); end
                end
                11: begin
                    checks++; if (valid_o !== 1'b1 || pc_o !== 14'h0201 || instr_o !== 32'h1201) begin
                        errors++; $display("FAIL redir_second got v=%b pc=%h i=%h exp v=1 pc=0201 i=00001201", valid_o, pc_o, instr_o); end
                end
                default: ;
            endcase
            @(negedge clk);
        end
        redirect_i = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        redirect_addr_i = 14'h3FFE;
        for (int c = 0; c < 9; c++) begin
            redirect_i = (c == 3);
            #1;
            if (c == 3) begin
                checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL wrap_redir_valid got %b exp 0", valid_o); end
            end
            if (c == 4) begin
                checks++; if (imem_addr_o !== 14'h3FFE) begin errors++; $display("FAIL wrap_addr4 got %h exp 3ffe", imem_addr_o); end
            end
            if (c == 6) begin
                checks++; if (imem_addr_o !== 14'h0000) begin errors++; $display("FAIL wrap_addr6 got %h exp 0000", imem_addr_o); end
                checks++; if (valid_o !== 1'b1 || pc_o !== 14'h3FFE || instr_o !== 32'h4FFE) begin
                    errors++; $display("FAIL wrap_pc6 got v=%b pc=%h i=%h exp v=1 pc=3ffe i=00004ffe", valid_o, pc_o, instr_o); end
            end
            if (c == 7) begin
                checks++; if (valid_o !== 1'b1 || pc_o !== 14'h3FFF || instr_o !== 32'h4FFF) begin
                    errors++; $display("FAIL wrap_pc7 got v=%b pc=%h i=%h exp v=1 pc=3fff i=00004fff", valid_o, pc_o, instr_o); end
            end
            if (c == 8) begin
                checks++; if (valid_o !== 1'b1 || pc_o !== 14'h0000 || instr_o !== exp_word(14'h0000)) begin
                    errors++; $display("FAIL wrap_pc8 got v=%b pc=%h i=%h exp v=1 pc=0000 i=%h", valid_o, pc_o, instr_o, exp_word(14'h0000)); end
            end
            @(negedge clk);
        end
        redirect_i = 1'b0;
    endtask

    task automatic test_upload();
        logic [13:0] exp_pc = '0;
        do_reset();
        for (int c = 0; c < 18; c++) begin
            if (c == 4) upg_rst_i = 1'b0;
            if (c == 5) begin upg_wen_i = 1'b1; upg_addr_i = 14'd5; upg_data_i = 32'hDEADBEEF; end
            if (c == 6) begin upg_wen_i = 1'b0; upg_addr_i = 14'd0; upg_data_i = '0; uploaded = 1'b1; end
            if (c == 7) upg_done_i = 1'b1;
            #1;
            if (c == 4) begin
                checks++; if (prog_mode_o !== 1'b1 || valid_o !== 1'b0 || imem_en_o !== 1'b0) begin
                    errors++; $display("FAIL upg_enter got pm=%b v=%b en=%b exp pm=1 v=0 en=0", prog_mode_o, valid_o, imem_en_o); end
            end
            if (c == 5) begin
                checks++; if (imem_en_o !== 1'b1 || imem_we_o !== 1'b1 || imem_addr_o !== 14'd5 || imem_wdata_o !== 32'hDEADBEEF) begin
                    errors++; $display("FAIL upg_write got en=%b we=%b addr=%h wd=%h exp en=1 we=1 addr=0005 wd=deadbeef",
                                       imem_en_o, imem_we_o, imem_addr_o, imem_wdata_o); end
            end
            if (c == 6) begin
                checks++; if (imem_en_o !== 1'b0 || valid_o !== 1'b0) begin
                    errors++; $display("FAIL upg_idle got en=%b v=%b exp en=0 v=0", imem_en_o, valid_o); end
            end
            if (c == 7) begin
                checks++; if (prog_mode_o !== 1'b0 || imem_en_o !== 1'b1 || imem_we_o !== 1'b0 ||
                              imem_addr_o !== 14'd0 || imem_wdata_o !== 32'd0) begin
                    errors++; $display("FAIL upg_leave got pm=%b en=%b we=%b addr=%h wd=%h exp pm=0 en=1 we=0 addr=0000 wd=00000000",
                                       prog_mode_o, imem_en_o, imem_we_o, imem_addr_o, imem_wdata_o); end
            end
            if (c >= 7 && valid_o && ready_i) begin
                checks++; if (pc_o !== exp_pc || instr_o !== exp_word(exp_pc)) begin
                    errors++; $display("FAIL upg_fetch c=%0d got pc=%h i=%h exp pc=%h i=%h", c, pc_o, instr_o, exp_pc, exp_word(exp_pc)); end
                exp_pc++;
            end
            @(negedge clk);
        end
        checks++; if (exp_pc !== 14'd9) begin errors++; $display("FAIL upg_popcount got %0d exp 9", exp_pc); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int c = 0; c < 6; c++) @(negedge clk);
        #1 rst_n = 1'b1;
        #1;
        checks++; if (valid_o !== 1'b0 || imem_en_o !== 1'b0) begin
            errors++; $display("FAIL arst_imm got v=%b en=%b exp v=0 en=0", valid_o, imem_en_o); end
        rst_n = 1'b0;
        #1;
        checks++; if (imem_addr_o !== 14'd0 || imem_en_o !== 1'b1 || valid_o !== 1'b0) begin
            errors++; $display("FAIL arst_clear got addr=%h en=%b v=%b exp addr=0000 en=1 v=0", imem_addr_o, imem_en_o, valid_o); end
        @(negedge clk); #1;
        checks++; if (imem_addr_o !== 14'd1) begin errors++; $display("FAIL arst_next got %h exp 0001", imem_addr_o); end
        @(negedge clk); #1;
        checks++; if (valid_o !== 1'b1 || pc_o !== 14'd0 || instr_o !== exp_word(14'd0)) begin
            errors++; $display("FAIL arst_first got v=%b pc=%h i=%h exp v=1 pc=0000 i=%h", valid_o, pc_o, instr_o, exp_word(14'd0)); end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 32'h1000 + i;
        imem_rdata_i = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_upload();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch_stream.md
Name: ifetch_stream

Overview:
Parametrised instruction-fetch unit and successor to the single-PC fetch stage. It drives a synchronous-read instruction memory (1-cycle read latency) and tags each fetched word with its PC. Fetched words are buffered in a DEPTH-entry FIFO and handed to decode over a valid/ready handshake. It supports branch redirect with flush, and a UART program-upload mode that takes over the memory port.

Parameters:
ADDR_W, 14, PC / memory address width (word address)
DATA_W, 32, instruction width
DEPTH, 4, fetch buffer entries; power of 2, >=2
RESET_PC, 0, PC after reset and after leaving upload mode
PC_STEP, 1, PC increment per fetched word

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  reset, asynchronous, active-high (1 = reset)
redirect_i  in  1  branch/jump taken; flush and reload PC
redirect_addr_i  in  ADDR_W  redirect target
instr_o  out  DATA_W  instruction at buffer head
pc_o  out  ADDR_W  PC of instr_o
valid_o  out  1  buffer head valid
ready_i  in  1  decode accepts head
imem_en_o  out  1  memory read/write enable
imem_we_o  out  1  memory write enable
imem_addr_o  out  ADDR_W  memory address
imem_wdata_o  out  DATA_W  memory write data
imem_rdata_i  in  DATA_W  read data, valid the cycle after imem_en_o & ~imem_we_o
upg_rst_i  in  1  UPG reset (1 = upload idle)
upg_wen_i  in  1  UPG write enable
upg_addr_i  in  ADDR_W  UPG write address
upg_data_i  in  DATA_W  UPG write data
upg_done_i  in  1  upload finished
prog_mode_o  out  1  1 while upload mode is active

Behaviour:
- Everything is synchronous to clk, including the upg_* inputs.
- run = upg_rst_i | upg_done_i. prog_mode_o = ~run (combinational).
- Reset: pc=RESET_PC, FIFO count=0, rd/wr pointers=0, inflight=0.
  - Outputs in reset: valid_o=0, imem_en_o=0, imem_we_o=0.
- Upload mode (run=0):
  - imem_en_o=upg_wen_i, imem_we_o=upg_wen_i, imem_addr_o=upg_addr_i, imem_wdata_o=upg_data_i.
  - No fetch is issued. FIFO is flushed. inflight=0. pc is held at RESET_PC. valid_o=0.
- Run mode: imem_we_o=0, imem_wdata_o=0, imem_addr_o=pc.
- pop = valid_o & ready_i.
- issue = run & ~redirect_i & (count + inflight - pop < DEPTH). imem_en_o = issue.
- On issue: pc <= pc + PC_STEP (modulo 2^ADDR_W wrap); inflight <= 1, and the issued PC is latched as the tag. Otherwise inflight <= 0.
- Response capture: when inflight=1 and redirect_i=0, {imem_rdata_i, tag} is written to the FIFO at the end of that cycle.
- valid_o = (count != 0) & ~redirect_i & run. instr_o and pc_o show the head entry; their values are don't-care when valid_o=0.
- Latency: a request issued in cycle N produces valid_o in cycle N+2.
  - Steady state with ready_i held high: one instruction per cycle, no bubbles.
- Redirect (redirect_i=1 for one cycle, run=1):
  - pc <= redirect_addr_i; FIFO flushed (count=0).
  - The in-flight response arriving that cycle is discarded; a pop in that cycle is ignored.
  - Next cycle: imem_addr_o=redirect_addr_i with imem_en_o=1.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Counts never exceed DEPTH; FIFO overflow is impossible by construction. Pop when empty is impossible since valid_o=0.
- Entering upload mode mid-stream: same flush as a redirect, with pc <= RESET_PC.
- Leaving upload mode (run 0->1): fetch restarts at RESET_PC on the first run cycle.
- Reset asserted mid-operation: immediate clear to the reset state, independent of clk.

Test Plan:
- Release reset, ready_i=1, memory word[i]=0x1000+i -> imem_en_o from cycle 0; valid_o from cycle 2; pc_o=0,1,2,...; instr_o=0x1000,0x1001,... one per cycle.
- ready_i=0 for 10 cycles after streaming starts -> exactly DEPTH=4 entries buffered, imem_en_o drops to 0, no word lost. Release -> pcs continue in order with no gap or duplicate.
- redirect_i pulse with redirect_addr_i=0x0200 while 3 entries are buffered and 1 is in flight -> valid_o=0 that cycle; next cycle imem_addr_o=0x0200. The next valid_o carries pc_o=0x0200; no stale instruction appears.
- upg_rst_i=0, upg_done_i=0, write 0xDEADBEEF at address 5 -> prog_mode_o=1, imem_we_o=1, imem_addr_o=5. Then upg_done_i=1 -> fetch restarts at RESET_PC and word 5 returns 0xDEADBEEF.
- Redirect to 0x3FFE with ADDR_W=14 -> pc_o sequence 0x3FFE, 0x3FFF, 0x0000.
- Assert rst_n=1 mid-stream between clock edges -> valid_o=0 and imem_en_o=0 immediately. After release, fetch restarts at RESET_PC.
